pool_wr_addr_gen: RTL
=====================

POOL_WR_ADDR_GEN -- requirements
Module: pool_wr_addr_gen

Interface
REQ-001 Parameter OUT_DIM, default 12: side length of the square pooled output map; a map holds OUT_DIM*OUT_DIM words.
REQ-002 Parameter N_CH, default 2: number of parallel output channels, one write port each.
REQ-003 Parameter ADDR_W, default 9: address width.
REQ-004 Parameter BASE, default 0: address of channel 0, word 0.
REQ-005 Parameter LATENCY, default 1: pipeline-fill cycles between start and the first legal write.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 start  in  1  one-cycle pulse that begins a frame.
REQ-009 enable  in  1  global advance; when 0, all state freezes.
REQ-010 in_valid  in  1  pooled result available this cycle.
REQ-011 wr_en  out  1  write strobe, common to all channels.
REQ-012 addr  out  N_CH x ADDR_W  per-channel write address.
REQ-013 row, col  out  clog2(OUT_DIM) each  position of the current word.
REQ-014 busy  out  1  high in the PRIME and RUN states.
REQ-015 done  out  1  frame complete; held until the next start or reset.

Function
REQ-016 States: IDLE, PRIME, RUN, DONE.
REQ-017 State transitions:
- IDLE -> PRIME on start=1. All other inputs are ignored in IDLE.
- PRIME: the delay counter loads LATENCY on entry and decrements on each cycle with enable=1. It moves to RUN in the cycle it reaches 0.
- LATENCY=0: the block goes IDLE -> RUN directly.
REQ-018 Word index idx runs 0..OUT_DIM*OUT_DIM-1. For channel k, addr[k] = BASE + k*OUT_DIM*OUT_DIM + idx, taken from registered idx.
REQ-019 wr_en = (state==RUN) & enable & in_valid. It is combinational. No other signal gates it.
REQ-020 On each wr_en cycle:
- idx increments.
- col increments; on col==OUT_DIM-1, col wraps to 0 and row increments.
REQ-021 When a write occurs with idx==OUT_DIM*OUT_DIM-1:
- The next state is DONE.
- idx, row and col are held at their final values.
REQ-022 In DONE:
- done=1 and wr_en=0.
- start=1 returns the block to PRIME (or to RUN if LATENCY=0) and clears idx, row, col and done on the same edge.
REQ-023 start in PRIME or RUN is ignored; no restart mid-frame.
REQ-024 With enable=0, no counter, state or output register changes. in_valid without enable never writes.
REQ-025 Address arithmetic is unsigned and never wraps. N_CH*OUT_DIM*OUT_DIM + BASE <= 2**ADDR_W is checked at elaboration, which fails if it is violated.
REQ-026 With in_valid=0 in RUN, the block stalls without limit; there is no timeout.

Reset
REQ-027 Reset asserted (reset=0) forces the following immediately, whatever the clock is doing:
- state=IDLE;
- idx, row, col, delay=0;
- done=0, busy=0, wr_en=0;
- addr[k]=BASE+k*OUT_DIM*OUT_DIM.
REQ-028 Reset in the middle of a frame abandons the frame. No done pulse is produced.
REQ-029 Release is synchronised to clk by the surrounding design; the block does not re-synchronise it.

Structure
REQ-030 Shared package pool_pkg holds:
- the state enum typedef pool_wr_state_t;
- a map-size function (OUT_DIM*OUT_DIM);
- an index-width function, for reuse by the C1/P2 write counters.
REQ-031 One sub-module, pool_rc_counter, holds the row/col/idx counting with its wrap and last-word flag. The top level holds the FSM, the delay counter and the address generation.

Verification (defaults unless stated)
REQ-032 Reset, then start with enable=1 and in_valid held at 1:
- PRIME lasts 1 cycle.
- wr_en goes high for exactly 144 cycles, with addr[0] stepping 0..143 and addr[1] stepping 144..287.
- done rises on the edge after the final write.
REQ-033 in_valid toggles 1-0-1 during RUN: addresses advance only on in_valid=1 cycles; 144 writes in total, none skipped or duplicated.
REQ-034 enable=0 for 5 cycles at idx=37 in the middle of a frame:
- addr, row=3 and col=1 hold.
- wr_en=0 throughout, even with in_valid=1.
REQ-035 reset=0 at idx=80: addr returns to {0,144} immediately and the state goes to IDLE; the next start writes from idx 0.
REQ-036 start pulsed during RUN is ignored. start pulsed in DONE restarts: done=0 on the next cycle, addr[0]=0.
REQ-037 With OUT_DIM=4, N_CH=3, BASE=16, LATENCY=3, ADDR_W=7:
- 3 PRIME cycles.
- addr[2] runs 48..63.
- row/col wrap at 3.
- done after 16 writes.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the pooling-layer write-address generators.
// Used by the P1 writer here and reusable by the C1/P2 write counters.
package pool_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPrime = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } pool_wr_state_t;

    // Words in one square output map.
    function automatic int unsigned map_size(input int unsigned out_dim);
        return out_dim * out_dim;
    endfunction

    // Bits needed to hold a word index 0..map_size-1 (at least one bit).
    function automatic int unsigned idx_width(input int unsigned out_dim);
        int unsigned words;
        words = map_size(out_dim);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Bits needed to hold a row or column 0..out_dim-1 (at least one bit).
    function automatic int unsigned rc_width(input int unsigned out_dim);
        return (out_dim > 1) ? $clog2(out_dim) : 1;
    endfunction

endpackage

// File: rtl/pool_rc_counter.sv
// Row/column/linear-index counter for one square output map.
// Advances once per write, holds on the last word, and raises last while there.
module pool_rc_counter
    import pool_pkg::*;
#(
    parameter int unsigned OUT_DIM = 12,
    parameter int unsigned IDX_W   = idx_width(OUT_DIM),
    parameter int unsigned RC_W    = rc_width(OUT_DIM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] idx,
    output logic [RC_W-1:0]  row,
    output logic [RC_W-1:0]  col,
    output logic             last
);

    localparam int unsigned MAP = map_size(OUT_DIM);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RC_W-1:0]  row_q, row_d;
    logic [RC_W-1:0]  col_q, col_d;
    logic             last_word;

    assign last_word = (idx_q == IDX_W'(MAP - 1));

    always_comb begin
        idx_d = idx_q;
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            idx_d = '0;
            row_d = '0;
            col_d = '0;
        end else if (advance && !last_word) begin
            // The final write leaves every counter parked on the last word.
            idx_d = idx_q + IDX_W'(1);
            if (col_q == RC_W'(OUT_DIM - 1)) begin
                col_d = '0;
                row_d = row_q + RC_W'(1);
            end else begin
                col_d = col_q + RC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            idx_q <= idx_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign idx  = idx_q;
    assign row  = row_q;
    assign col  = col_q;
    assign last = last_word;

endmodule

// File: rtl/pool_wr_addr_gen.sv
// Write-address generator for a pooled output map: one address per channel,
// a pipeline-fill delay after start, and a sticky done at the end of the frame.
module pool_wr_addr_gen
    import pool_pkg::*;
#(
    parameter int unsigned OUT_DIM = 12,
    parameter int unsigned N_CH    = 2,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned BASE    = 0,
    parameter int unsigned LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             enable,
    input  logic                             in_valid,
    output logic                             wr_en,
    output logic [N_CH-1:0][ADDR_W-1:0]      addr,
    output logic [rc_width(OUT_DIM)-1:0]     row,
    output logic [rc_width(OUT_DIM)-1:0]     col,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned MAP   = map_size(OUT_DIM);
    localparam int unsigned IDX_W = idx_width(OUT_DIM);
    localparam int unsigned RC_W  = rc_width(OUT_DIM);
    localparam int unsigned DLY_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    if (longint'(N_CH) * longint'(MAP) + longint'(BASE) > (longint'(1) << ADDR_W))
    begin : g_addr_range_check
        $error("pool_wr_addr_gen: N_CH*OUT_DIM*OUT_DIM + BASE exceeds 2**ADDR_W");
    end

    pool_wr_state_t   state_q, state_d;
    logic [DLY_W-1:0] delay_q, delay_d;
    logic             cnt_clear;
    logic             cnt_last;
    logic [IDX_W-1:0] idx;

    assign wr_en = (state_q == StRun) && enable && in_valid;

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        cnt_clear = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                // A frame start clears the counters and, from DONE, drops done.
                if (enable && start) begin
                    cnt_clear = 1'b1;
                    if (LATENCY == 0) begin
                        state_d = StRun;
                    end else begin
                        state_d = StPrime;
                        delay_d = DLY_W'(LATENCY);
                    end
                end
            end
            StPrime: begin
                if (enable) begin
                    delay_d = delay_q - DLY_W'(1);
                    if (delay_q == DLY_W'(1)) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (wr_en && cnt_last) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
        end
    end

    pool_rc_counter #(
        .OUT_DIM (OUT_DIM),
        .IDX_W   (IDX_W),
        .RC_W    (RC_W)
    ) u_rc_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .advance (wr_en),
        .idx     (idx),
        .row     (row),
        .col     (col),
        .last    (cnt_last)
    );

    // Addresses follow the registered index, so reset moves them at once.
    always_comb begin
        for (int k = 0; k < int'(N_CH); k++) begin
            addr[k] = ADDR_W'(BASE + k * MAP) + ADDR_W'(idx);
        end
    end

    assign busy = (state_q == StPrime) || (state_q == StRun);
    assign done = (state_q == StDone);

endmodule
